// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry type codes and the per-entry record.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE_DEF = 16;
    localparam int unsigned TAG_W_DEF    = 4;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic      busy;
        logic      ready;
        rob_type_e typ;
        logic [4:0]  dest;
        logic [31:0] pred_pc;
        logic [31:0] next_pc;
        logic [31:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode/dispatch/CDB/commit signal bundle of the reorder buffer.
// slave = the ROB itself, master = the core (or bench) around it.
interface reorder_buffer_if #(parameter int unsigned TAG_W = 4);

    logic             ID_valid;
    logic [1:0]       ID_type;
    logic [4:0]       ID_reg_dest;
    logic [31:0]      ID_pred_pc;
    logic             ID_full;
    logic [TAG_W-1:0] ID_tag;

    logic [TAG_W-1:0] dispatch_tag1;
    logic [TAG_W-1:0] dispatch_tag2;
    logic             dispatch_ready1;
    logic             dispatch_ready2;
    logic [31:0]      dispatch_data1;
    logic [31:0]      dispatch_data2;

    logic             ALU_valid;
    logic [TAG_W-1:0] ALU_tag;
    logic [31:0]      ALU_data;
    logic [31:0]      ALU_next_pc;
    logic             LSB_valid;
    logic [TAG_W-1:0] LSB_tag;
    logic [31:0]      LSB_data;

    logic             LSB_store_commit;
    logic             regfile_data_valid;
    logic [4:0]       regfile_reg_dest;
    logic [TAG_W-1:0] regfile_tag;
    logic [31:0]      regfile_data;
    logic             clear;
    logic [31:0]      IF_redirect_pc;

    modport slave (
        input  ID_valid, ID_type, ID_reg_dest, ID_pred_pc,
        output ID_full, ID_tag,
        input  dispatch_tag1, dispatch_tag2,
        output dispatch_ready1, dispatch_ready2, dispatch_data1, dispatch_data2,
        input  ALU_valid, ALU_tag, ALU_data, ALU_next_pc,
        input  LSB_valid, LSB_tag, LSB_data,
        output LSB_store_commit, regfile_data_valid, regfile_reg_dest, regfile_tag,
        output regfile_data, clear, IF_redirect_pc
    );

    modport master (
        output ID_valid, ID_type, ID_reg_dest, ID_pred_pc,
        input  ID_full, ID_tag,
        output dispatch_tag1, dispatch_tag2,
        input  dispatch_ready1, dispatch_ready2, dispatch_data1, dispatch_data2,
        output ALU_valid, ALU_tag, ALU_data, ALU_next_pc,
        output LSB_valid, LSB_tag, LSB_data,
        input  LSB_store_commit, regfile_data_valid, regfile_reg_dest, regfile_tag,
        input  regfile_data, clear, IF_redirect_pc
    );

endinterface

// File: rtl/reorder_buffer_lookup.sv
// Two combinational operand-lookup ports of the ROB.
// Build option ROB_CDB_BYPASS_EN: also match this cycle's ALU/LSB broadcast (ALU first).
module reorder_buffer_lookup #(
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned TAG_W    = 4
) (
    input  logic [ROB_SIZE-1:0] i_busy,
    input  logic [ROB_SIZE-1:0] i_ready,
    input  logic [31:0]         i_data [ROB_SIZE],
    input  logic [TAG_W-1:0]    i_tag1,
    input  logic [TAG_W-1:0]    i_tag2,
    input  logic                i_alu_valid,
    input  logic [TAG_W-1:0]    i_alu_tag,
    input  logic [31:0]         i_alu_data,
    input  logic                i_lsb_valid,
    input  logic [TAG_W-1:0]    i_lsb_tag,
    input  logic [31:0]         i_lsb_data,
    output logic                o_ready1,
    output logic [31:0]         o_data1,
    output logic                o_ready2,
    output logic [31:0]         o_data2
);

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
    } lookup_t;

    function automatic lookup_t lookup(input logic [TAG_W-1:0] tag);
        lookup_t r;
        r.ready = i_busy[tag] & i_ready[tag];
        r.data  = i_data[tag];
`ifdef ROB_CDB_BYPASS_EN
        if (i_busy[tag]) begin
            if (i_alu_valid && (i_alu_tag == tag)) begin
                r.ready = 1'b1;
                r.data  = i_alu_data;
            end else if (i_lsb_valid && (i_lsb_tag == tag)) begin
                r.ready = 1'b1;
                r.data  = i_lsb_data;
            end
        end
`endif
        return r;
    endfunction

`ifndef ROB_CDB_BYPASS_EN
    logic w_unused_cdb;
    assign w_unused_cdb = ^{i_alu_valid, i_alu_tag, i_alu_data, i_lsb_valid, i_lsb_tag, i_lsb_data};
`endif

    lookup_t w_lk1, w_lk2;

    always_comb begin
        w_lk1 = lookup(i_tag1);
        w_lk2 = lookup(i_tag2);
    end

    assign o_ready1 = w_lk1.ready;
    assign o_data1  = w_lk1.data;
    assign o_ready2 = w_lk2.ready;
    assign o_data2  = w_lk2.data;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocation, CDB capture, single in-order retire, mispredict flush.
// Build option ROB_CDB_BYPASS_EN enables CDB bypass on the lookup ports.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_SIZE = ROB_SIZE_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    reorder_buffer_if.slave  bus
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_SIZE);

    rob_entry_t       r_entry [ROB_SIZE];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic             r_rf_valid;
    logic [4:0]       r_rf_dest;
    logic [TAG_W-1:0] r_rf_tag;
    logic [31:0]      r_rf_data;
    logic             r_store_commit;
    logic             r_clear;
    logic [31:0]      r_redirect_pc;

    rob_entry_t          w_head_e;
    logic                w_full, w_alloc, w_commit, w_mispredict;
    logic                w_alu_hit, w_lsb_hit;
    logic [ROB_SIZE-1:0] w_busy, w_ready;
    logic [31:0]         w_data [ROB_SIZE];

    assign w_head_e     = r_entry[r_head];
    assign w_full       = (r_count == FULL_COUNT);
    assign w_alloc      = bus.ID_valid & ~w_full;
    assign w_commit     = (r_count != '0) & w_head_e.ready;
    assign w_mispredict = w_commit & (w_head_e.typ == ROB_BRANCH) & (w_head_e.next_pc != w_head_e.pred_pc);
    assign w_alu_hit    = bus.ALU_valid & r_entry[bus.ALU_tag].busy;
    assign w_lsb_hit    = bus.LSB_valid & r_entry[bus.LSB_tag].busy
                          & ~(bus.ALU_valid & (bus.ALU_tag == bus.LSB_tag));

    assign bus.ID_full = w_full;
    assign bus.ID_tag  = r_tail;

    // Ready is cleared on retire, so a set ready bit always belongs to a live entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) r_entry[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (w_mispredict) begin
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    r_entry[i].busy  <= 1'b0;
                    r_entry[i].ready <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_lsb_hit) begin
                    r_entry[bus.LSB_tag].ready <= 1'b1;
                    r_entry[bus.LSB_tag].data  <= bus.LSB_data;
                end
                if (w_alu_hit) begin
                    r_entry[bus.ALU_tag].ready   <= 1'b1;
                    r_entry[bus.ALU_tag].data    <= bus.ALU_data;
                    r_entry[bus.ALU_tag].next_pc <= bus.ALU_next_pc;
                end
                if (w_alloc) begin
                    r_entry[r_tail] <= '{busy: 1'b1, ready: 1'b0, typ: rob_type_e'(bus.ID_type),
                                         dest: bus.ID_reg_dest, pred_pc: bus.ID_pred_pc,
                                         next_pc: bus.ID_pred_pc, data: '0};
                    r_tail <= r_tail + 1'b1;
                end
                if (w_commit) begin
                    r_entry[r_head].busy  <= 1'b0;
                    r_entry[r_head].ready <= 1'b0;
                    r_head <= r_head + 1'b1;
                end
                r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_valid     <= 1'b0;
            r_rf_dest      <= '0;
            r_rf_tag       <= '0;
            r_rf_data      <= '0;
            r_store_commit <= 1'b0;
            r_clear        <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            r_rf_valid     <= 1'b0;
            r_store_commit <= 1'b0;
            r_clear        <= 1'b0;
            if (rdy && w_commit) begin
                if (w_head_e.typ == ROB_STORE) begin
                    r_store_commit <= 1'b1;
                end else begin
                    r_rf_valid <= 1'b1;
                    r_rf_dest  <= w_head_e.dest;
                    r_rf_tag   <= r_head;
                    r_rf_data  <= w_head_e.data;
                end
                if (w_mispredict) begin
                    r_clear       <= 1'b1;
                    r_redirect_pc <= w_head_e.next_pc;
                end
            end
        end
    end

    assign bus.regfile_data_valid = r_rf_valid;
    assign bus.regfile_reg_dest   = r_rf_dest;
    assign bus.regfile_tag        = r_rf_tag;
    assign bus.regfile_data       = r_rf_data;
    assign bus.LSB_store_commit   = r_store_commit;
    assign bus.clear              = r_clear;
    assign bus.IF_redirect_pc     = r_redirect_pc;

    always_comb begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            w_busy[i]  = r_entry[i].busy;
            w_ready[i] = r_entry[i].ready;
            w_data[i]  = r_entry[i].data;
        end
    end

    reorder_buffer_lookup #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_lookup (
        .i_busy      (w_busy),
        .i_ready     (w_ready),
        .i_data      (w_data),
        .i_tag1      (bus.dispatch_tag1),
        .i_tag2      (bus.dispatch_tag2),
        .i_alu_valid (bus.ALU_valid),
        .i_alu_tag   (bus.ALU_tag),
        .i_alu_data  (bus.ALU_data),
        .i_lsb_valid (bus.LSB_valid),
        .i_lsb_tag   (bus.LSB_tag),
        .i_lsb_data  (bus.LSB_data),
        .o_ready1    (bus.dispatch_ready1),
        .o_data1     (bus.dispatch_data1),
        .o_ready2    (bus.dispatch_ready2),
        .o_data2     (bus.dispatch_data2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, corner sequences, random vs queue model.
module tb_reorder_buffer;

    localparam int unsigned N = 16;

    logic clk;
    logic rst;
    logic rdy;

    reorder_buffer_if #(.TAG_W(4)) bus ();

    reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ROB_CDB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.ID_valid = 0; bus.ID_type = 0; bus.ID_reg_dest = 0; bus.ID_pred_pc = 0;
        bus.ALU_valid = 0; bus.ALU_tag = 0; bus.ALU_data = 0; bus.ALU_next_pc = 0;
        bus.LSB_valid = 0; bus.LSB_tag = 0; bus.LSB_data = 0;
        bus.dispatch_tag1 = 0; bus.dispatch_tag2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] ty, input logic [4:0] dst, input logic [31:0] pred);
        idle_inputs();
        bus.ID_valid = 1; bus.ID_type = ty; bus.ID_reg_dest = dst; bus.ID_pred_pc = pred;
        tick();
    endtask

    task automatic chk_outputs_zero(input string tagname);
        chk({tagname, "_rfv"},   bus.regfile_data_valid, 0);
        chk({tagname, "_dest"},  bus.regfile_reg_dest, 0);
        chk({tagname, "_rtag"},  bus.regfile_tag, 0);
        chk({tagname, "_rdata"}, bus.regfile_data, 0);
        chk({tagname, "_store"}, bus.LSB_store_commit, 0);
        chk({tagname, "_clear"}, bus.clear, 0);
        chk({tagname, "_redir"}, bus.IF_redirect_pc, 0);
        chk({tagname, "_full"},  bus.ID_full, 0);
        chk({tagname, "_idtag"}, bus.ID_tag, 0);
        chk({tagname, "_drdy1"}, bus.dispatch_ready1, 0);
        chk({tagname, "_drdy2"}, bus.dispatch_ready2, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rdy; logic idv; logic [1:0] ty; logic [4:0] dst; logic [31:0] pred;
        logic av; logic [3:0] at; logic [31:0] ad; logic [31:0] anpc;
        logic lv; logic [3:0] lt; logic [31:0] ld;
        logic [3:0] e_tag;
        logic e_rfv; logic [4:0] e_dst; logic [3:0] e_rtag; logic [31:0] e_data;
        logic e_st; logic e_clr; logic [31:0] e_redir;
    } vec_t;

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] tag; logic [1:0] typ; logic [4:0] dst;
        logic [31:0] pred; logic [31:0] data; logic [31:0] npc; bit rdy;
    } m_ent_t;

    m_ent_t      m_q[$];
    int unsigned m_head;
    logic        e_rfv, e_st, e_clr;
    logic [4:0]  e_dst;
    logic [3:0]  e_rtag;
    logic [31:0] e_data, e_redir;

    function automatic int m_find(input logic [3:0] t);
        foreach (m_q[i]) if (m_q[i].tag == t) return i;
        return -1;
    endfunction

    task automatic m_lookup(input logic [3:0] t, output logic r, output logic [31:0] d);
        int k;
        r = 0; d = 0;
        k = m_find(t);
        if (k >= 0) begin
            r = m_q[k].rdy; d = m_q[k].data;
`ifdef ROB_CDB_BYPASS_EN
            if (bus.ALU_valid && bus.ALU_tag == t) begin r = 1; d = bus.ALU_data; end
            else if (bus.LSB_valid && bus.LSB_tag == t) begin r = 1; d = bus.LSB_data; end
`endif
        end
    endtask

    // One clock of the ROB rules, evaluated from the pre-edge state and current inputs.
    task automatic m_step();
        int n;
        bit commit;
        m_ent_t h, ne;
        n = m_q.size();
        e_rfv = 0; e_st = 0; e_clr = 0;
        if (!rdy) return;
        commit = (n > 0) && m_q[0].rdy;
        if (commit) begin
            h = m_q[0];
            if (h.typ == 2'd1) e_st = 1;
            else begin e_rfv = 1; e_dst = h.dst; e_rtag = h.tag; e_data = h.data; end
            if (h.typ == 2'd2 && h.npc != h.pred) begin
                e_clr = 1; e_redir = h.npc;
                m_q.delete(); m_head = 0;
                return;
            end
        end
        foreach (m_q[i]) begin
            if (bus.ALU_valid && m_q[i].tag == bus.ALU_tag) begin
                m_q[i].rdy = 1; m_q[i].data = bus.ALU_data; m_q[i].npc = bus.ALU_next_pc;
            end else if (bus.LSB_valid && m_q[i].tag == bus.LSB_tag) begin
                m_q[i].rdy = 1; m_q[i].data = bus.LSB_data;
            end
        end
        if (bus.ID_valid && n < N) begin
            ne.tag = 4'((m_head + n) % N); ne.typ = bus.ID_type; ne.dst = bus.ID_reg_dest;
            ne.pred = bus.ID_pred_pc; ne.data = 0; ne.npc = bus.ID_pred_pc; ne.rdy = 0;
            m_q.push_back(ne);
        end
        if (commit) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % N;
        end
    endtask

    function automatic logic [3:0] pick_tag();
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
            return m_q[$urandom_range(0, m_q.size() - 1)].tag;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic rand_inputs();
        int k, r;
        idle_inputs();
        rdy = ($urandom_range(0, 9) != 0);
        bus.ID_valid = $urandom_range(0, 1);
        r = $urandom_range(0, 9);
        bus.ID_type = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : 2'd2;
        bus.ID_reg_dest = 5'($urandom);
        bus.ID_pred_pc = {22'($urandom), 10'h0};
        if ($urandom_range(0, 9) < 6) begin
            bus.ALU_valid = 1; bus.ALU_tag = pick_tag(); bus.ALU_data = $urandom;
            k = m_find(bus.ALU_tag);
            bus.ALU_next_pc = (k >= 0 && $urandom_range(0, 4) != 0) ? m_q[k].pred : $urandom;
        end
        if ($urandom_range(0, 9) < 4) begin
            bus.LSB_valid = 1; bus.LSB_tag = pick_tag(); bus.LSB_data = $urandom;
            k = m_find(bus.LSB_tag);
            if ((k >= 0 && m_q[k].typ == 2'd2) || (bus.ALU_valid && bus.ALU_tag == bus.LSB_tag))
                bus.LSB_valid = 0;
        end
        bus.dispatch_tag1 = pick_tag();
        bus.dispatch_tag2 = pick_tag();
    endtask

    initial begin
        vec_t vt[22];
        logic        lr;
        logic [31:0] ld;

        //        rdy idv ty dst pred     av at ad      anpc     lv lt ld  etag rfv dst rt data    st clr redir
        vt[0]  = '{1, 1, 0, 5, 0,       0, 0, 0,      0,       0, 0, 0,  0,   0, 0, 0, 0,      0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 0,       1, 0, 'h2A,   0,       0, 0, 0,  1,   0, 0, 0, 0,      0, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  1,   1, 5, 0, 'h2A,   0, 0, 0};
        vt[3]  = '{1, 1, 0, 7, 0,       0, 0, 0,      0,       0, 0, 0,  1,   0, 0, 0, 0,      0, 0, 0};
        vt[4]  = '{1, 1, 1, 0, 0,       0, 0, 0,      0,       0, 0, 0,  2,   0, 0, 0, 0,      0, 0, 0};
        vt[5]  = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       1, 2, 0,  3,   0, 0, 0, 0,      0, 0, 0};
        vt[6]  = '{1, 0, 0, 0, 0,       1, 1, 'h11,   0,       0, 0, 0,  3,   0, 0, 0, 0,      0, 0, 0};
        vt[7]  = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  3,   1, 7, 1, 'h11,   0, 0, 0};
        vt[8]  = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  3,   0, 0, 0, 0,      1, 0, 0};
        vt[9]  = '{1, 1, 2, 1, 'h104,   0, 0, 0,      0,       0, 0, 0,  3,   0, 0, 0, 0,      0, 0, 0};
        vt[10] = '{1, 0, 0, 0, 0,       1, 3, 'h100,  'h104,   0, 0, 0,  4,   0, 0, 0, 0,      0, 0, 0};
        vt[11] = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  4,   1, 1, 3, 'h100,  0, 0, 0};
        vt[12] = '{1, 1, 2, 0, 'h104,   0, 0, 0,      0,       0, 0, 0,  4,   0, 0, 0, 0,      0, 0, 0};
        vt[13] = '{1, 0, 0, 0, 0,       1, 4, 'h55,   'h200,   0, 0, 0,  5,   0, 0, 0, 0,      0, 0, 0};
        vt[14] = '{1, 1, 0, 9, 0,       0, 0, 0,      0,       0, 0, 0,  5,   1, 0, 4, 'h55,   0, 1, 'h200};
        vt[15] = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  0,   0, 0, 0, 0,      0, 0, 0};
        vt[16] = '{0, 1, 0, 3, 0,       0, 0, 0,      0,       0, 0, 0,  0,   0, 0, 0, 0,      0, 0, 0};
        vt[17] = '{1, 1, 0, 3, 0,       0, 0, 0,      0,       0, 0, 0,  0,   0, 0, 0, 0,      0, 0, 0};
        vt[18] = '{1, 0, 0, 0, 0,       1, 0, 'h33,   0,       0, 0, 0,  1,   0, 0, 0, 0,      0, 0, 0};
        vt[19] = '{0, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  1,   0, 0, 0, 0,      0, 0, 0};
        vt[20] = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  1,   1, 3, 0, 'h33,   0, 0, 0};
        vt[21] = '{1, 0, 0, 0, 0,       0, 0, 0,      0,       0, 0, 0,  1,   0, 0, 0, 0,      0, 0, 0};

        do_reset();
        chk_outputs_zero("reset");

        foreach (vt[i]) begin
            idle_inputs();
            rdy = vt[i].rdy;
            bus.ID_valid = vt[i].idv; bus.ID_type = vt[i].ty; bus.ID_reg_dest = vt[i].dst;
            bus.ID_pred_pc = vt[i].pred;
            bus.ALU_valid = vt[i].av; bus.ALU_tag = vt[i].at; bus.ALU_data = vt[i].ad;
            bus.ALU_next_pc = vt[i].anpc;
            bus.LSB_valid = vt[i].lv; bus.LSB_tag = vt[i].lt; bus.LSB_data = vt[i].ld;
            #1;
            chk($sformatf("vec%0d_full", i), bus.ID_full, 0);
            chk($sformatf("vec%0d_idtag", i), bus.ID_tag, vt[i].e_tag);
            tick();
            chk($sformatf("vec%0d_rfv", i), bus.regfile_data_valid, vt[i].e_rfv);
            chk($sformatf("vec%0d_store", i), bus.LSB_store_commit, vt[i].e_st);
            chk($sformatf("vec%0d_clear", i), bus.clear, vt[i].e_clr);
            if (vt[i].e_rfv) begin
                chk($sformatf("vec%0d_dest", i), bus.regfile_reg_dest, vt[i].e_dst);
                chk($sformatf("vec%0d_rtag", i), bus.regfile_tag, vt[i].e_rtag);
                chk($sformatf("vec%0d_rdata", i), bus.regfile_data, vt[i].e_data);
            end
            if (vt[i].e_clr) chk($sformatf("vec%0d_redir", i), bus.IF_redirect_pc, vt[i].e_redir);
        end

        // Fill all 16 entries, refuse the 17th, then free one slot by commit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            bus.ID_valid = 1; bus.ID_reg_dest = 5'(i + 1);
            #1 chk("fill_idtag", bus.ID_tag, i);
            chk("fill_notfull", bus.ID_full, 0);
            tick();
        end
        idle_inputs();
        #1 chk("full_set", bus.ID_full, 1);
        chk("full_tail_wrap", bus.ID_tag, 0);
        bus.ID_valid = 1; bus.ID_reg_dest = 20;
        bus.ALU_valid = 1; bus.ALU_tag = 0; bus.ALU_data = 'h77;
        tick();
        idle_inputs();
        bus.ID_valid = 1; bus.ID_reg_dest = 21;
        #1 chk("full_still_set", bus.ID_full, 1);
        tick();
        chk("full_commit_rfv", bus.regfile_data_valid, 1);
        chk("full_commit_tag", bus.regfile_tag, 0);
        chk("full_commit_dest", bus.regfile_reg_dest, 1);
        chk("full_commit_data", bus.regfile_data, 'h77);
        chk("full_cleared", bus.ID_full, 0);
        chk("full_free_tag", bus.ID_tag, 0);
        alloc(0, 31, 0);
        chk("full_again", bus.ID_full, 1);

        // Operand lookup during an ALU broadcast and on a non-busy tag.
        do_reset();
        for (int i = 0; i < 4; i++) alloc(0, 5'(i + 2), 0);
        idle_inputs();
        bus.ALU_valid = 1; bus.ALU_tag = 3; bus.ALU_data = 'hAB;
        bus.dispatch_tag1 = 3; bus.dispatch_tag2 = 9;
        #1 chk("byp_ready", bus.dispatch_ready1, BYP);
`ifdef ROB_CDB_BYPASS_EN
        chk("byp_data", bus.dispatch_data1, 'hAB);
`endif
        chk("lookup_nonbusy", bus.dispatch_ready2, 0);
        tick();
        idle_inputs();
        bus.dispatch_tag1 = 3; bus.dispatch_tag2 = 2;
        #1 chk("lookup_ready", bus.dispatch_ready1, 1);
        chk("lookup_data", bus.dispatch_data1, 'hAB);
        chk("lookup_pending", bus.dispatch_ready2, 0);
        tick();

        // Asynchronous reset with 7 live entries and a commit pulse showing.
        do_reset();
        for (int i = 0; i < 7; i++) alloc(0, 5'(i + 10), 32'(i));
        idle_inputs();
        bus.ALU_valid = 1; bus.ALU_tag = 0; bus.ALU_data = 'h99;
        tick();
        idle_inputs();
        bus.dispatch_tag1 = 1; bus.dispatch_tag2 = 0;
        tick();
        chk("pre_rst_rfv", bus.regfile_data_valid, 1);
        chk("pre_rst_dest", bus.regfile_reg_dest, 10);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        bus.ID_valid = 1; bus.ID_reg_dest = 4;
        #1 chk("post_rst_tag", bus.ID_tag, 0);
        tick();
        idle_inputs();
        #1 chk("post_rst_next_tag", bus.ID_tag, 1);

        // Randomized traffic against the queue model.
        do_reset();
        m_q.delete(); m_head = 0;
        e_rfv = 0; e_st = 0; e_clr = 0; e_dst = 0; e_rtag = 0; e_data = 0; e_redir = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_inputs();
            #1;
            chk("rnd_full", bus.ID_full, (m_q.size() == N));
            chk("rnd_idtag", bus.ID_tag, (m_head + m_q.size()) % N);
            m_lookup(bus.dispatch_tag1, lr, ld);
            chk("rnd_drdy1", bus.dispatch_ready1, lr);
            if (lr) chk("rnd_ddata1", bus.dispatch_data1, ld);
            m_lookup(bus.dispatch_tag2, lr, ld);
            chk("rnd_drdy2", bus.dispatch_ready2, lr);
            if (lr) chk("rnd_ddata2", bus.dispatch_data2, ld);
            m_step();
            tick();
            chk("rnd_rfv", bus.regfile_data_valid, e_rfv);
            chk("rnd_store", bus.LSB_store_commit, e_st);
            chk("rnd_clear", bus.clear, e_clr);
            if (e_rfv) begin
                chk("rnd_dest", bus.regfile_reg_dest, e_dst);
                chk("rnd_rtag", bus.regfile_tag, e_rtag);
                chk("rnd_rdata", bus.regfile_data, e_data);
            end
            if (e_clr) chk("rnd_redir", bus.IF_redirect_pc, e_redir);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
